// File: rtl/alu_bit_serial_seq.sv
// alu_bit_serial_seq
// Bit-serial sequencer wrapped around an external 1-bit ALU slice. It latches
// two WIDTH-bit operands and a 4-bit ALU control word. It then feeds the slice
// one bit per cycle, LSB first, closing the carry chain through a register and
// shifting the slice result back into a WIDTH-bit result register. A FIX cycle
// patches SLT bit 0 and computes the zero/overflow flags. A DONE cycle pulses
// done.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               operation request, honoured only in IDLE
//   alu_ctl[3:0]        {ainvert, bnegate, op[1:0]}
//   opa, opb            operands, sampled when start is accepted
//   slice_a/b/cin       current operand bits and carry into the slice
//   slice_ainvert/bnegate/op/set_less  slice control (zero outside RUN)
//   slice_result/cout/set  slice result bit, carry out, adder sum bit
//   busy                high in RUN and FIX
//   done                one-cycle pulse when result/zero/overflow are valid
//   result, zero, overflow  held until the FIX cycle of the next operation
module alu_bit_serial_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       alu_ctl,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic             slice_a,
  output logic             slice_b,
  output logic             slice_cin,
  output logic             slice_ainvert,
  output logic             slice_bnegate,
  output logic [1:0]       slice_op,
  output logic             slice_set_less,
  input  logic             slice_result,
  input  logic             slice_cout,
  input  logic             slice_set,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow
);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);
  localparam logic [3:0]       CTL_SLT  = 4'b0111;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH-1:0]   res_sh_q, res_sh_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [3:0]         ctl_q, ctl_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic               set_msb_q, set_msb_d;
  logic               ovf_raw_q, ovf_raw_d;
  logic               zero_q, zero_d;
  logic               overflow_q, overflow_d;
  logic               last_bit;

  assign last_bit = (idx_q == LAST_IDX);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_bit) state_d = FIX;
      FIX:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: slice drive is gated to RUN so the slice sees zeros otherwise
  always_comb begin
    busy           = 1'b0;
    done           = 1'b0;
    slice_a        = 1'b0;
    slice_b        = 1'b0;
    slice_cin      = 1'b0;
    slice_ainvert  = 1'b0;
    slice_bnegate  = 1'b0;
    slice_op       = 2'b00;
    slice_set_less = 1'b0;
    unique case (state_q)
      RUN: begin
        busy          = 1'b1;
        slice_a       = a_sh_q[0];
        slice_b       = b_sh_q[0];
        slice_cin     = carry_q;
        slice_ainvert = ctl_q[3];
        slice_bnegate = ctl_q[2];
        slice_op      = ctl_q[1:0];
      end
      FIX:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Datapath next-state
  always_comb begin
    a_sh_d     = a_sh_q;
    b_sh_d     = b_sh_q;
    res_sh_d   = res_sh_q;
    result_d   = result_q;
    ctl_d      = ctl_q;
    idx_d      = idx_q;
    carry_d    = carry_q;
    set_msb_d  = set_msb_q;
    ovf_raw_d  = ovf_raw_q;
    zero_d     = zero_q;
    overflow_d = overflow_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d   = opa;
          b_sh_d   = opb;
          ctl_d    = alu_ctl;
          // bnegate doubles as the +1 of the two's-complement subtract
          carry_d  = alu_ctl[2];
          idx_d    = '0;
          res_sh_d = '0;
        end
      end
      RUN: begin
        res_sh_d = {slice_result, res_sh_q[WIDTH-1:1]};
        carry_d  = slice_cout;
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        idx_d    = idx_q + CNT_W'(1);
        if (last_bit) begin
          set_msb_d = slice_set;
          ovf_raw_d = carry_q ^ slice_cout;
        end
      end
      FIX: begin
        result_d = res_sh_q;
        // SLT: raw sign of A-B, no overflow correction
        if (ctl_q == CTL_SLT) result_d[0] = set_msb_q;
        zero_d     = (result_d == '0);
        overflow_d = (ctl_q[1:0] == 2'b10) ? ovf_raw_q : 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh_q     <= '0;
      b_sh_q     <= '0;
      res_sh_q   <= '0;
      result_q   <= '0;
      ctl_q      <= '0;
      idx_q      <= '0;
      carry_q    <= 1'b0;
      set_msb_q  <= 1'b0;
      ovf_raw_q  <= 1'b0;
      zero_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      a_sh_q     <= a_sh_d;
      b_sh_q     <= b_sh_d;
      res_sh_q   <= res_sh_d;
      result_q   <= result_d;
      ctl_q      <= ctl_d;
      idx_q      <= idx_d;
      carry_q    <= carry_d;
      set_msb_q  <= set_msb_d;
      ovf_raw_q  <= ovf_raw_d;
      zero_q     <= zero_d;
      overflow_q <= overflow_d;
    end
  end

  assign result   = result_q;
  assign zero     = zero_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_alu_bit_serial_seq.sv
module tb_alu_bit_serial_seq;

  localparam int W  = 32;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [3:0]    alu_ctl;
  logic [W-1:0]  opa, opb;
  logic          slice_a, slice_b, slice_cin, slice_ainvert, slice_bnegate;
  logic [1:0]    slice_op;
  logic          slice_set_less;
  logic          slice_result, slice_cout, slice_set;
  logic          busy, done, zero, overflow;
  logic [W-1:0]  result;

  always #5 clk = ~clk;

  alu_bit_serial_seq #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .alu_ctl(alu_ctl),
    .opa(opa), .opb(opb),
    .slice_a(slice_a), .slice_b(slice_b), .slice_cin(slice_cin),
    .slice_ainvert(slice_ainvert), .slice_bnegate(slice_bnegate),
    .slice_op(slice_op), .slice_set_less(slice_set_less),
    .slice_result(slice_result), .slice_cout(slice_cout), .slice_set(slice_set),
    .busy(busy), .done(done), .result(result), .zero(zero), .overflow(overflow)
  );

  // 1-bit ALU slice the sequencer drives
  logic sa, sb, ssum;
  always_comb begin
    sa         = slice_a ^ slice_ainvert;
    sb         = slice_b ^ slice_bnegate;
    ssum       = sa ^ sb ^ slice_cin;
    slice_set  = ssum;
    slice_cout = (sa & sb) | (sa & slice_cin) | (sb & slice_cin);
    case (slice_op)
      2'b00:   slice_result = sa & sb;
      2'b01:   slice_result = sa | sb;
      2'b10:   slice_result = ssum;
      default: slice_result = slice_set_less;
    endcase
  end

  // Reference model: whole-word arithmetic, returns {result, zero, overflow}
  function automatic logic [W+1:0] model(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] ap, bp, r;
    logic [W:0]   s;
    logic         ov;
    ap = c[3] ? ~a : a;
    bp = c[2] ? ~b : b;
    s  = {1'b0, ap} + {1'b0, bp} + {{W{1'b0}}, c[2]};
    ov = 1'b0;
    case (c[1:0])
      2'b00: r = ap & bp;
      2'b01: r = ap | bp;
      2'b10: begin
        r  = s[W-1:0];
        ov = (ap[W-1] == bp[W-1]) && (s[W-1] != ap[W-1]);
      end
      default: r = (c == 4'b0111) ? {{(W-1){1'b0}}, s[W-1]} : '0;
    endcase
    return {r, (r == '0), ov};
  endfunction

  int          checks = 0;
  int          fails  = 0;
  int unsigned cyc    = 0;
  int          done_cnt = 0;
  bit          sl_bad = 1'b0;
  bit          idle_bad = 1'b0;
  logic [W+1:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
    checks++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Monitor / scoreboard
  initial begin
    logic [W+1:0] e;
    forever begin
      @(negedge clk);
      if (slice_set_less !== 1'b0) sl_bad = 1'b1;
      if (busy === 1'b0 &&
          {slice_a, slice_b, slice_cin, slice_ainvert, slice_bnegate, slice_op} !== 7'd0)
        idle_bad = 1'b1;
      if (done === 1'b1) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_done: done seen with no pending operation (cycle %0d)", cyc);
        end else begin
          e = exp_q.pop_front();
          check("result",   result,        e[W+1:2]);
          check("zero",     {31'd0, zero},     {31'd0, e[1]});
          check("overflow", {31'd0, overflow}, {31'd0, e[0]});
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    forever begin
      @(negedge clk);
      if (busy === 1'b0 && done === 1'b0) break;
      n++;
      if (n > 200) begin
        $display("FAIL wait_idle: timeout, busy=%b done=%b", busy, done);
        $fatal(1, "timeout");
      end
    end
  endtask

  task automatic do_op(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    int unsigned t0;
    int n;
    wait_idle();
    start = 1'b1; alu_ctl = c; opa = a; opb = b;
    @(posedge clk); #1;
    t0 = cyc;
    start = 1'b0;
    exp_q.push_back(model(c, a, b));
    // scramble inputs mid-run; latched values must be used
    opa = $urandom; opb = $urandom; alu_ctl = 4'($urandom);
    n = 0;
    forever begin
      @(negedge clk);
      if (done === 1'b1) break;
      n++;
      if (n > 100) break;
    end
    if (done === 1'b1) check("latency", cyc - t0, W + 1);
    else begin
      checks++; fails++;
      $display("FAIL done_timeout: got no done expected done after %0d cycles", W + 1);
    end
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return 32'h7FFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int d0, busy_cnt;
    int unsigned t0;
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, busy_cnt;
    int unsigned t0;
    rst = 1'b1; start = 1'b0; alu_ctl = '0; opa = '0; opb = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_result", result, '0);
    check("rst_flags", {28'd0, busy, done, zero, overflow}, '0);

    // directed cases
    do_op(4'b0010, 32'd5, 32'd7);
    do_op(4'b0110, 32'd3, 32'd5);
    do_op(4'b0110, 32'h1234, 32'h1234);
    do_op(4'b0111, 32'hFFFF_FFFF, 32'd1);
    do_op(4'b0111, 32'd1, 32'hFFFF_FFFF);
    do_op(4'b0010, 32'h7FFF_FFFF, 32'd1);
    do_op(4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00);
    do_op(4'b0001, 32'hF0F0_F0F0, 32'hFF00_FF00);
    do_op(4'b1100, 32'hF0F0_F0F0, 32'hFF00_FF00);
    do_op(4'b0110, 32'd0, 32'h8000_0000);

    // start held high through RUN/FIX/DONE with changing operands
    wait_idle();
    d0 = done_cnt;
    start = 1'b1; alu_ctl = 4'b0010; opa = 32'd100; opb = 32'd23;
    @(posedge clk); #1;
    t0 = cyc;
    exp_q.push_back(model(4'b0010, 32'd100, 32'd23));
    busy_cnt = 0;
    for (int k = 0; k <= W + 2; k++) begin
      @(negedge clk);
      if ((cyc - t0) >= 1 && (cyc - t0) <= W && busy === 1'b1) busy_cnt++;
      opa = $urandom; opb = $urandom;
    end
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("hold_busy_cycles", busy_cnt, W);
    check("hold_done_count", done_cnt - d0, 1);

    // reset in the middle of RUN
    wait_idle();
    d0 = done_cnt;
    start = 1'b1; alu_ctl = 4'b0010; opa = 32'd9; opb = 32'd9;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_busy", {31'd0, busy}, '0);
    check("midrst_result", result, '0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("midrst_no_done", done_cnt - d0, 0);
    do_op(4'b0010, 32'd1, 32'd1);

    // randomized operations over all control codes
    for (int i = 0; i < 30; i++) do_op(4'($urandom), pick(), pick());

    repeat (4) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    check("set_less_zero", {31'd0, sl_bad}, '0);
    check("slice_idle_zero", {31'd0, idle_bad}, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
